// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store width
// codes, responder state encoding and the store byte-enable helper.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
    logic [3:0] mask;
    case (funct3)
      MEM_B, MEM_BU: mask = 4'b0001 << offset;
      MEM_H, MEM_HU: mask = offset[1] ? 4'b1100 : 4'b0011;
      MEM_W:         mask = 4'b1111;
      default:       mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: combinational read, byte-enabled synchronous write.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one request at a time, fixed latency,
// byte-lane stores, sign/zero-extended loads, stall toward the hazard unit while busy.
//   state | meaning
//   IDLE  | ready; accepts a request on req_valid
//   WAIT  | counting down the access latency
//   RESP  | one-cycle response; a store commits on this edge
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        StallMemM
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam bit         MULTI    = (LATENCY > 1);

  dmem_state_t state, state_next;
  logic [3:0]  cnt;
  logic        accept;

  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        cur_we;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;

  logic        misaligned;
  logic        illegal;
  logic        out_of_range;
  logic        cur_err;

  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        mem_we;

  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = reset && (state == IDLE);
  assign StallMemM = reset && (accept || (state == WAIT));
  assign rsp_valid = reset && (state == RESP);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = MULTI ? WAIT : RESP;
      WAIT:    if (cnt == 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY=1 the response is captured on the accept edge, so the
  // request is still on the input pins rather than in the latch.
  assign cur_we     = (state == IDLE) ? req_we     : lat_we;
  assign cur_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
  assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (cur_funct3)
      MEM_B:   misaligned = 1'b0;
      MEM_BU:  illegal = cur_we;
      MEM_H:   misaligned = cur_addr[0];
      MEM_HU: begin
        misaligned = cur_addr[0];
        illegal    = cur_we;
      end
      MEM_W:   misaligned = |cur_addr[1:0];
      default: illegal = 1'b1;
    endcase
  end

  assign out_of_range = (cur_addr >> (AW + 2)) != 32'd0;
  assign cur_err      = misaligned | illegal | out_of_range;

  assign rd_shift = rd_word >> {cur_addr[1:0], 3'b000};

  always_comb begin
    ld_data = 32'd0;
    case (cur_funct3)
      MEM_B:   ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      MEM_H:   ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      MEM_W:   ld_data = rd_shift;
      MEM_BU:  ld_data = {24'd0, rd_shift[7:0]};
      MEM_HU:  ld_data = {16'd0, rd_shift[15:0]};
      default: ld_data = 32'd0;
    endcase
  end

  always_comb begin
    st_data = lat_wdata;
    case (lat_funct3)
      MEM_B:   st_data = {4{lat_wdata[7:0]}};
      MEM_H:   st_data = {2{lat_wdata[15:0]}};
      default: st_data = lat_wdata;
    endcase
  end

  // rsp_err is already the registered error of the latched request in RESP.
  assign st_be  = lane_mask(lat_funct3, lat_addr[1:0]);
  assign mem_we = reset && (state == RESP) && lat_we && !rsp_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        lat_we     <= req_we;
        lat_funct3 <= req_funct3;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        cnt        <= CNT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state_next == RESP) begin
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_err || cur_we) ? 32'd0 : ld_data;
      end else begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (st_be),
    .addr (cur_addr[AW+1:2]),
    .wdata(st_data),
    .rdata(rd_word)
  );

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the five-stage core: the target end of the load/store requests the MEM stage issues. It accepts one request at a time, models a fixed access latency, performs byte/halfword/word stores with lane steering, and returns sign/zero-extended load data. While a request is in flight it raises a stall toward the hazard unit, which holds the pipeline.

## Interface
- DEPTH_WORDS, 1024: storage size in 32-bit words; power of two, ≥ 4.
- LATENCY, 2: cycles from request acceptance to response; legal range 1–15.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range, or illegal funct3; qualified by rsp_valid.
- StallMemM  out  1  to hazard unit: hold IF/ID/EX/MEM.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata, load cnt=LATENCY-1; go WAIT if LATENCY>1, else RESP.
  - WAIT: decrement cnt; when cnt==1, go RESP.
  - RESP: rsp_valid=1 for exactly one cycle; store commit happens on this clock edge; go IDLE.
- StallMemM = (IDLE & req_valid) | WAIT. It is low in RESP, so the pipeline advances on the response cycle.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Out of range means addr ≥ 4·DEPTH_WORDS.
- Errors:
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Out of range.
  - funct3 ∈ {011, 110, 111}, or funct3 ∈ {100, 101} with we=1.
  - On error: rsp_err=1, rsp_rdata=0, no memory write.
- Store lanes:
  - SB: lane addr[1:0], wdata[7:0] replicated to all lanes.
  - SH: lanes {2·addr[1], 2·addr[1]+1}, wdata[15:0] replicated.
  - SW: all four lanes.
- Load: select the byte/half by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Reset asserted in any state: next state IDLE, latched request discarded, pending store not committed, memory contents retained (not cleared).

## Timing
- Reset values: req_ready=0 while reset is low, 1 from the first cycle after release; rsp_valid=0; rsp_rdata=0; rsp_err=0; StallMemM=0.
- Request accepted at edge T → rsp_valid high during cycle T+LATENCY → next accept no earlier than T+LATENCY+1.
- Throughput is one access per LATENCY+1 cycles.
- rsp_rdata and rsp_err are registered; stable only while rsp_valid is high.
- A store followed by a load to the same address returns the new data: the commit at the RESP edge precedes the next read.
- req_* changes outside IDLE are ignored.

## Structure
- Shared package mem_pkg holds:
  - funct3 width constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU);
  - state enum dmem_state_t;
  - function lane_mask(funct3, addr[1:0]) returning the 4-bit byte enable.
- One sub-module, dmem_array: DEPTH_WORDS×32 storage with combinational read and synchronous byte-enabled write. The FSM, counter, error check, lane steering and extension stay in dmem_responder.

## Test plan
- LATENCY=2: SW addr 0x10 data 0xDEADBEEF at T → StallMemM high in T and T+1, rsp_valid at T+2 with err=0; then LW 0x10 → rdata 0xDEADBEEF.
- SB 0x13 data 0x80 over 0x00000000 → word 0x80000000; LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LH 0x12 → 0xFFFF8000.
- LH 0x11 → err=1, rdata=0; SW 0x1002 → err=1 and word 0x1000 unchanged; LW 0x1000 with DEPTH_WORDS=1024 → err=1.
- LATENCY=1: back-to-back req_valid → rsp_valid every second cycle, StallMemM high only in accept cycles.
- SW 0x20 data 0x12345678 with reset pulsed low in WAIT → IDLE next cycle, no rsp_valid, LW 0x20 returns prior value.
- funct3=011 load → err=1; funct3=100 with we=1 → err=1 and no write.
